// File: rtl/block_lock_66.sv
// block_lock_66: 64b/66b sync-header block lock with internal slipping.
module block_lock_66 #(
  parameter int W         = 66,
  parameter int LOCK_CNT  = 64,
  parameter int INVLD_MAX = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_enable,
  input  logic           in_pop,
  input  logic [W-1:0]   in_data,
  output logic [W-3:0]   out_data,
  output logic [1:0]     out_header,
  output logic           out_pop,
  output logic           block_lock,
  output logic           sh_invalid
);
  typedef enum logic [1:0] {LOCK_INIT, TEST, SLIP} state_t;
  state_t       r_state;
  logic [W-1:0] r_prev;
  logic [6:0]   r_offset;
  logic [6:0]   r_sh_cnt;
  logic [4:0]   r_invld;
  logic         w_acc;
  logic [2*W-1:0] w_x;
  logic [W-1:0] w_blk;
  logic         w_bad;
  logic [6:0]   w_cnt;
  logic [4:0]   w_inv;
  logic         w_slip;
  logic [6:0]   w_off_nxt;
  always_comb begin
    w_acc     = in_enable & in_pop;
    w_x       = {in_data, r_prev};
    w_blk     = W'(w_x >> r_offset);
    w_bad     = w_blk[1] ~^ w_blk[0];
    w_cnt     = r_sh_cnt + 7'd1;
    w_inv     = r_invld + {4'd0, w_bad};
    // unlocked slips on any bad header; locked only once the window budget is spent
    w_slip    = block_lock ? (w_inv == 5'(INVLD_MAX)) : w_bad;
    w_off_nxt = (r_offset == 7'(W-1)) ? 7'd0 : r_offset + 7'd1;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= LOCK_INIT;
      r_prev     <= '0;
      r_offset   <= '0;
      r_sh_cnt   <= '0;
      r_invld    <= '0;
      out_data   <= '0;
      out_header <= '0;
      out_pop    <= 1'b0;
      block_lock <= 1'b0;
      sh_invalid <= 1'b0;
    end else if (!w_acc) begin
      out_pop    <= 1'b0;
      sh_invalid <= 1'b0;
    end else begin
      r_prev <= in_data;
      if (r_state == LOCK_INIT) begin
        r_state    <= TEST;
        out_pop    <= 1'b0;
        sh_invalid <= 1'b0;
      end else begin
        r_state    <= w_slip ? SLIP : TEST;
        out_pop    <= 1'b1;
        out_data   <= w_blk[W-1:2];
        out_header <= w_blk[1:0];
        sh_invalid <= w_bad;
        if (w_slip) begin
          r_offset   <= w_off_nxt;
          r_sh_cnt   <= '0;
          r_invld    <= '0;
          block_lock <= 1'b0;
        end else if (w_cnt == 7'(LOCK_CNT)) begin
          r_sh_cnt   <= '0;
          r_invld    <= '0;
          block_lock <= 1'b1;
        end else begin
          r_sh_cnt <= w_cnt;
          r_invld  <= w_inv;
        end
      end
    end
  end
endmodule

// File: doc/block_lock_66.md
# block_lock_66

Receive-path 64b/66b block synchronizer for the 25G PCS. It sits directly upstream of the 64-bit descrambler. It takes unaligned 66-bit words from the RX gearbox and finds the sync-header boundary using the IEEE 802.3 clause 49 lock algorithm, adapted so that slips are done internally. It emits aligned 64-bit scrambled payloads with their 2-bit sync header, plus a lock indication.

## Interface
- W, 66: input word width; fixed to one 66-bit block per pop.
- LOCK_CNT, 64: consecutive valid headers required to gain lock.
- INVLD_MAX, 16: invalid headers within a 64-block window that drop lock.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_enable  input  1  global stage enable; when low, all state holds.
- in_pop  input  1  in_data carries a new 66-bit word this cycle.
- in_data  input  66  raw received bits; bit 0 is the earliest on the line.
- out_data  output  64  aligned payload, block bits [65:2]; feeds the descrambler in_data.
- out_header  output  2  aligned sync header, block bits [1:0].
- out_pop  output  1  out_data/out_header valid this cycle; feeds the descrambler in_pop.
- block_lock  output  1  high while block lock is held.
- sh_invalid  output  1  one-cycle pulse with out_pop when the output header is 00 or 11.

## Operation
- An accepted word is a cycle with in_enable & in_pop. Only accepted words change state.
- prev_data (66 b) holds the previous accepted word.
- Window X = {in_data, prev_data}, 132 b, with earlier bits low.
- offset register, range 0..65. Aligned block B = X[offset+65 : offset].
- Header test: valid iff B[1:0] is 01 or 10.
- Counters:
  - sh_cnt, 7 b: blocks tested in the current window.
  - sh_invld_cnt, 5 b: invalid headers in the current window.
- States: LOCK_INIT, TEST, SLIP. Only TEST and SLIP are reachable after reset.
- LOCK_INIT (reset state): on the first accepted word, load prev_data only, with no test and no output. Then go to TEST.
- TEST, unlocked (block_lock=0):
  - Valid header: sh_cnt+1. When sh_cnt reaches LOCK_CNT, set block_lock=1 and clear both counters.
  - Invalid header: go to SLIP.
- TEST, locked:
  - Every tested block: sh_cnt+1; an invalid header also does sh_invld_cnt+1.
  - If sh_invld_cnt reaches INVLD_MAX: clear block_lock and go to SLIP. This takes priority over the window end.
  - Else if sh_cnt reaches LOCK_CNT: clear both counters and stay locked.
- SLIP:
  - Applied in the same cycle it is decided: offset = (offset==65) ? 0 : offset+1.
  - Both counters cleared, block_lock=0, return to TEST.
  - The next accepted word is tested at the new offset.
- Output:
  - out_pop is asserted for every accepted word after LOCK_INIT, regardless of lock.
  - Downstream uses block_lock to qualify data.
  - out_data = B[65:2], out_header = B[1:0], sh_invalid = header test failed.
- in_enable low: no register changes, out_pop=0.

## Timing
- Reset values: out_data=0, out_header=0, out_pop=0, block_lock=0, sh_invalid=0, offset=0, counters=0, prev_data=0, state LOCK_INIT.
- Latency: all outputs are registered. An accepted word at cycle N gives out_pop/out_data at N+1.
- block_lock rises in the cycle after the 64th consecutive valid header is accepted. It falls in the cycle after the 16th invalid header in a window.
- The window boundary and the 16th invalid header can fall on the same block; loss of lock wins.
- Offset wrap: 65 -> 0 without skipping any position.
- Back-to-back pops every cycle are supported with no bubbles. Gaps in in_pop do not age any counter.
- reset_n asserted mid-operation clears everything asynchronously. After release, the first accepted word is again consumed by LOCK_INIT.

## Test plan
- Aligned stream, all headers 01, in_pop every cycle, offset 0:
  - block_lock=0 through the first 64 tested blocks, then rises one cycle after the 64th.
  - out_data equals the sent payload with 1-cycle latency.
- Stream shifted by 17 bits:
  - exactly 17 slips occur (offset 0->17) before lock.
  - Lock is reached after 64 further valid blocks.
  - Payloads after lock match the source.
- Locked link, inject 15 bad headers (00) in one 64-block window:
  - lock is held and counters reset at the window end.
  - Inject 16 in the next window: block_lock falls one cycle after the 16th, offset increments by 1.
- Shift of 65 bits, then force one more slip:
  - offset wraps 65->0.
  - The bench checks the block extraction at offsets 65 and 0.
- in_pop toggling 1/0 and in_enable low for 10 cycles mid-stream:
  - no state change while disabled, out_pop=0 in those cycles.
  - The lock count resumes exactly where it stopped.
- reset_n pulsed low while locked at offset 30:
  - all outputs are 0 immediately, offset=0.
  - The first word after reset produces no out_pop.
